// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg
//   Shared definitions for the stream demultiplexer.
//   - state_e       : packet-tracking FSM states (IDLE, PASS, DROP)
//   - DEFAULT_CNT_W : default width of the dropped-packet counter
package stream_demux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    localparam int DEFAULT_CNT_W = 16;

endpackage

// File: rtl/stream_demux_oreg.sv
// stream_demux_oreg
//   Single-entry output register with load/drain handshake.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     load_i      : write payload_i this edge (entry becomes valid)
//     drain_i     : consumer takes the current entry this edge
//     payload_i   : {data, last, ch} to store
//     vld_o       : entry holds a beat
//     payload_o   : stored {data, last, ch}; held after drain
module stream_demux_oreg #(
    parameter int PAYLOAD_W = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic                 drain_i,
    input  logic [PAYLOAD_W-1:0] payload_i,
    output logic                 vld_o,
    output logic [PAYLOAD_W-1:0] payload_o
);

    logic                 vld_q, vld_d;
    logic [PAYLOAD_W-1:0] payload_q, payload_d;

    // Load wins over drain: a drain and a load on the same edge leaves the
    // entry valid with the new beat.
    always_comb begin
        vld_d     = vld_q;
        payload_d = payload_q;
        if (load_i) begin
            vld_d     = 1'b1;
            payload_d = payload_i;
        end else if (drain_i) begin
            vld_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q     <= 1'b0;
            payload_q <= '0;
        end else begin
            vld_q     <= vld_d;
            payload_q <= payload_d;
        end
    end

    assign vld_o     = vld_q;
    assign payload_o = payload_q;

endmodule

// File: rtl/stream_demux.sv
// stream_demux
//   Registered 1-to-N stream demultiplexer with packet-locked channel select.
//   The select is sampled on the first beat of a packet and held until the
//   last beat; packets whose select is out of range are swallowed and counted.
//   Handshake: a beat moves when valid and ready are both high at a rising
//   edge; ready never depends combinationally on the same side's valid.
//   Ports:
//     clk, rst_n          : clock, asynchronous active-low reset
//     en                  : global enable for accepting new beats
//     in_valid/in_ready   : upstream handshake
//     in_data/in_sel/in_last : upstream beat payload, select, end of packet
//     out_valid/out_ready : per-channel one-hot valid and consumer ready
//     out_data/out_last   : shared payload and end-of-packet flag
//     drop_cnt            : saturating count of dropped packets
//     busy                : packet in progress or output register full
//     dbg_state           : current FSM state (state_e encoding)
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int N_OUT  = 8,
    parameter  int CNT_W  = DEFAULT_CNT_W,
    localparam int SEL_W  = $clog2(N_OUT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic              in_last,
    output logic [N_OUT-1:0]  out_valid,
    input  logic [N_OUT-1:0]  out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam int PAYLOAD_W = DATA_W + 1 + SEL_W;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   ch_q, ch_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               o_vld;
    logic [DATA_W-1:0]  o_data;
    logic               o_last;
    logic [SEL_W-1:0]   o_ch;
    logic               drain_rdy;
    logic               accept;
    logic               sel_ok;
    logic               load;
    logic [SEL_W-1:0]   load_ch;

    // Only the channel currently held in the register can drain it.
    assign drain_rdy = out_ready[o_ch];
    assign sel_ok    = ({1'b0, in_sel} < (SEL_W+1)'(N_OUT));

    // rst_n gating keeps in_ready low while reset is asserted. DROP swallows
    // beats without touching the register, so it ignores en and backpressure.
    assign in_ready = rst_n &&
                      ((state_q == ST_DROP) || (en && (!o_vld || drain_rdy)));
    assign accept   = in_valid && in_ready;

    assign load    = accept && (((state_q == ST_IDLE) && sel_ok) ||
                                (state_q == ST_PASS));
    assign load_ch = (state_q == ST_IDLE) ? in_sel : ch_q;

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (sel_ok) begin
                        ch_d = in_sel;
                        if (!in_last) state_d = ST_PASS;
                    end else begin
                        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
                        if (!in_last) state_d = ST_DROP;
                    end
                end
            end
            ST_PASS: begin
                if (accept && in_last) state_d = ST_IDLE;
            end
            ST_DROP: begin
                if (accept && in_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
        end
    end

    stream_demux_oreg #(
        .PAYLOAD_W (PAYLOAD_W)
    ) u_oreg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (load),
        .drain_i   (o_vld && drain_rdy),
        .payload_i ({in_data, in_last, load_ch}),
        .vld_o     (o_vld),
        .payload_o ({o_data, o_last, o_ch})
    );

    assign out_valid = o_vld ? ({{(N_OUT-1){1'b0}}, 1'b1} << o_ch) : '0;
    assign out_data  = o_data;
    assign out_last  = o_last;
    assign drop_cnt  = cnt_q;
    assign busy      = (state_q != ST_IDLE) || o_vld;
    assign dbg_state = state_q;

endmodule

// File: doc/stream_demux.md
# stream_demux

Parametrised, registered 1-to-N stream demultiplexer with valid/ready handshaking and packet-locked channel selection. It generalises the combinational 1-to-8 demux: arbitrary data width and channel count, an enable, a one-beat output register, per-packet select latching and dropping of packets with an out-of-range select. It sits between a single upstream producer and N independent consumers in the datapath.

## Interface
- DATA_W, 8, payload width in bits
- N_OUT, 8, number of output channels (2..64)
- SEL_W, $clog2(N_OUT), select width (derived, not overridden)
- CNT_W, 16, drop-counter width
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  global enable; low blocks acceptance of new beats
- in_valid  input  1  upstream beat valid
- in_ready  output  1  block accepts beat this cycle
- in_data  input  DATA_W  payload
- in_sel  input  SEL_W  destination channel, sampled on first beat of packet only
- in_last  input  1  last beat of packet
- out_valid  output  N_OUT  one-hot per-channel valid
- out_ready  input  N_OUT  per-channel consumer ready
- out_data  output  DATA_W  payload, shared by all channels
- out_last  output  1  last flag, shared
- drop_cnt  output  CNT_W  saturating count of dropped packets
- busy  output  1  high while a packet is in progress (state not IDLE) or output register full

## Operation
- Handshake: beat transfers when in_valid && in_ready at a rising edge; output beat transfers when out_valid[ch] && out_ready[ch].
- Output register: one entry {data, last, ch, vld}. out_valid = vld ? (1 << ch) : 0. out_data/out_last driven from register regardless of vld.
- FSM states: IDLE, PASS, DROP.
- IDLE: first beat accepted with in_sel < N_OUT → load register, ch := in_sel; go PASS unless in_last (stay IDLE). With in_sel >= N_OUT → discard beat, drop_cnt++ (saturating at all-ones); go DROP unless in_last (stay IDLE).
- PASS: in_sel ignored; beats go to latched ch; in_last accepted → IDLE.
- DROP: beats discarded, in_ready = 1 regardless of en; in_last accepted → IDLE.
- in_ready (IDLE/PASS) = en && (!vld || out_ready[ch]); no combinational path from in_valid to in_ready.
- en low mid-packet: acceptance stalls, state and ch held, register still drains; resume when en returns.
- in_valid may drop between beats of a packet; lock is kept.

## Timing
- Reset (async assert, sync release via rst_n): state IDLE, vld 0, out_valid 0, out_data 0, out_last 0, ch 0, drop_cnt 0, busy 0, in_ready 0 during reset.
- Latency: accepted beat appears on out_* at the next rising edge (1 cycle).
- Throughput: 1 beat/cycle when selected channel's out_ready held high.
- Simultaneous drain and load same edge: register reloads, vld stays 1.
- Back-to-back packets to different channels: second packet's first beat accepted only when register empty or draining that cycle; no bubble when out_ready[old ch] high.
- out_ready of non-selected channels is ignored.
- Reset mid-packet: data in register lost, no partial packet resumes; drop_cnt cleared.

## Structure
- Package stream_demux_pkg: state enum (IDLE, PASS, DROP) and the default CNT_W constant.
- Sub-module stream_demux_oreg: the single-entry output register with load/drain handshake (DATA_W+1+SEL_W payload); FSM, select lock and drop counter stay in top.

## Test plan
- Reset then en=1, N_OUT=8: 4-beat packet sel=3, data 0xA1..0xA4, all out_ready=1 → out_valid=0x08 cycles 2–5, data in order, out_last on 0xA4, busy falls after.
- Select lock: packet sel=2, in_sel changed to 5 on beats 2–3 → all beats on out_valid=0x04.
- N_OUT=6: packet sel=7 of 3 beats, then packet sel=1 → first packet never appears, drop_cnt=1, second on out_valid=0x02; drop_cnt saturates at 0xFFFF after 65536+ drops.
- Backpressure: out_ready[4]=0 for 5 cycles mid-packet → in_ready=0, out_data held stable, no loss or duplication after release.
- en toggled low for 10 cycles mid-packet and one-beat packets back-to-back to channels 0,7,0 → no beats lost, correct channels, full throughput when en=1.
- rst_n asserted mid-packet with vld=1 → outputs zero asynchronously; after release, new packet sel=0 routes correctly.
